// File: rtl/pad_io_ctrl_if.sv
// Pad I/O controller bus: configuration, pad-cell pins and filtered status.
// master = the side that configures the block and models the pad cells,
// slave  = pad_io_ctrl itself.
interface pad_io_ctrl_if #(
    parameter int NCH  = 32,
    parameter int DB_W = 8
);
    logic [NCH-1:0]  cfg_oe;
    logic [NCH-1:0]  cfg_out;
    logic [NCH-1:0]  cfg_pue;
    logic [DB_W-1:0] cfg_db_cyc;
    logic [NCH-1:0]  cfg_rise_en;
    logic [NCH-1:0]  cfg_fall_en;
    logic [NCH-1:0]  irq_clr;
    logic [NCH-1:0]  pad_c;
    logic [NCH-1:0]  pad_i;
    logic [NCH-1:0]  pad_oen;
    logic [NCH-1:0]  pad_ren;
    logic [NCH-1:0]  in_val;
    logic [NCH-1:0]  pend;
    logic            irq;

    modport master (
        output cfg_oe, cfg_out, cfg_pue, cfg_db_cyc, cfg_rise_en, cfg_fall_en,
        output irq_clr, pad_c,
        input  pad_i, pad_oen, pad_ren, in_val, pend, irq
    );

    modport slave (
        input  cfg_oe, cfg_out, cfg_pue, cfg_db_cyc, cfg_rise_en, cfg_fall_en,
        input  irq_clr, pad_c,
        output pad_i, pad_oen, pad_ren, in_val, pend, irq
    );
endinterface

// File: rtl/pad_io_ctrl.sv
// Pad I/O controller: registered pad-cell drive (I/OEN/REN), two-flop input
// synchroniser, optional per-channel debounce filter and edge-pending flags
// with an OR-reduced interrupt.
// Build option: define PAD_IO_DEBOUNCE_EN to include the debounce filter;
// without it the filtered input simply follows the synchroniser output.
module pad_io_ctrl #(
    parameter int NCH  = 32,
    parameter int DB_W = 8
) (
    input  logic         clk,
    input  logic         rst,
    pad_io_ctrl_if.slave bus
);

    logic [NCH-1:0] pad_i_q, pad_oen_q, pad_ren_q;
    logic [NCH-1:0] s1, s2;
    logic [NCH-1:0] in_val_q, in_val_nxt;
    logic [NCH-1:0] pend_q, pend_set;

    // Pad-cell drive registers: one cycle from configuration to pins.
    always_ff @(posedge clk) begin
        // NOTE: state registers use non-blocking assignments so every flop
        // samples pre-edge values regardless of statement order.
        if (rst) begin
            pad_i_q   <= '0;
            pad_oen_q <= '1;
            pad_ren_q <= '0;
        end else begin
            pad_i_q   <= bus.cfg_out;
            pad_oen_q <= ~bus.cfg_oe;
            pad_ren_q <= ~bus.cfg_pue;
        end
    end

    // Two-flop synchroniser for the asynchronous pad inputs.
    always_ff @(posedge clk) begin
        if (rst) begin
            s1 <= '0;
            s2 <= '0;
        end else begin
            s1 <= bus.pad_c;
            s2 <= s1;
        end
    end

`ifdef PAD_IO_DEBOUNCE_EN
    logic [DB_W-1:0] cnt [NCH];

    // A channel accepts its synchronised value once it has disagreed with
    // in_val for more than cfg_db_cyc consecutive cycles.
    always_comb begin
        // NOTE: default first so every path assigns in_val_nxt and no latch forms.
        in_val_nxt = in_val_q;
        for (int n = 0; n < NCH; n++) begin
            if ((s2[n] != in_val_q[n]) && (cnt[n] >= bus.cfg_db_cyc)) begin
                in_val_nxt[n] = s2[n];
            end
        end
    end

    // Per-channel run-length counters; >= lets a lowered threshold finish at once.
    always_ff @(posedge clk) begin
        for (int n = 0; n < NCH; n++) begin
            // NOTE: the counter array is real control state, so it is reset
            // explicitly; a stale count would accept a glitch after reset.
            if (rst) begin
                cnt[n] <= '0;
            end else if (s2[n] == in_val_q[n]) begin
                cnt[n] <= '0;
            end else if (cnt[n] >= bus.cfg_db_cyc) begin
                cnt[n] <= '0;
            end else begin
                cnt[n] <= cnt[n] + DB_W'(1);
            end
        end
    end
`else
    logic unused_db_cyc;

    // Without the filter the synchroniser output is the filtered value.
    assign in_val_nxt    = s2;
    assign unused_db_cyc = ^bus.cfg_db_cyc;
`endif

    // Enabled edges on the filtered value raise the pending flag.
    assign pend_set = (in_val_nxt & ~in_val_q & bus.cfg_rise_en)
                    | (~in_val_nxt & in_val_q & bus.cfg_fall_en);

    // Filtered value and pending flags; a set beats a same-edge clear.
    always_ff @(posedge clk) begin
        if (rst) begin
            in_val_q <= '0;
            pend_q   <= '0;
        end else begin
            in_val_q <= in_val_nxt;
            pend_q   <= pend_set | (pend_q & ~bus.irq_clr);
        end
    end

    assign bus.pad_i   = pad_i_q;
    assign bus.pad_oen = pad_oen_q;
    assign bus.pad_ren = pad_ren_q;
    assign bus.in_val  = in_val_q;
    assign bus.pend    = pend_q;
    assign bus.irq     = |pend_q;

endmodule

// File: doc/pad_io_ctrl.md
PAD_IO_CTRL -- requirements
Module: pad_io_ctrl

Interface
REQ-001 SHALL have parameter NCH, default 32: number of bidirectional pad channels.
REQ-002 SHALL have parameter DB_W, default 8: debounce counter and threshold width.
REQ-003 SHALL have port clk, input, 1: single clock; all state updates on its rising edge.
REQ-004 SHALL have port rst, input, 1: reset; synchronous and active-high.
REQ-005 SHALL have port cfg_oe, input, NCH: per-channel output enable (1 = drive pad).
REQ-006 SHALL have port cfg_out, input, NCH: per-channel output value.
REQ-007 SHALL have port cfg_pue, input, NCH: per-channel pull-up enable (1 = pull on).
REQ-008 SHALL have port cfg_db_cyc, input, DB_W: debounce threshold in cycles, shared by all channels.
REQ-009 SHALL have port cfg_rise_en, input, NCH: rising-edge capture enable.
REQ-010 SHALL have port cfg_fall_en, input, NCH: falling-edge capture enable.
REQ-011 SHALL have port irq_clr, input, NCH: per-channel clear of the pending flag, write-1-to-clear, one-cycle pulse.
REQ-012 SHALL have port pad_c, input, NCH: raw asynchronous input from the pad cell C pin.
REQ-013 SHALL have port pad_i, output, NCH: to the pad cell I pin.
REQ-014 SHALL have port pad_oen, output, NCH: to the pad cell OEN pin, active-low.
REQ-015 SHALL have port pad_ren, output, NCH: to the pad cell REN pin, active-low.
REQ-016 SHALL have port in_val, output, NCH: filtered input value.
REQ-017 SHALL have port pend, output, NCH: edge-pending flags.
REQ-018 SHALL have port irq, output, 1: OR-reduction of pend.

Function
REQ-019 SHALL register pad_i, pad_oen and pad_ren from cfg_out, ~cfg_oe and ~cfg_pue respectively, with exactly 1 cycle of latency.
REQ-020 SHALL pass each pad_c bit through a two-flop synchroniser (s1, s2) before any other use.
REQ-021 SHALL keep, per channel, a DB_W-bit counter cnt whose value never exceeds cfg_db_cyc.
REQ-022 SHALL update the debounce logic each cycle per channel as follows:
- if s2 == in_val: cnt <= 0.
- else if cnt >= cfg_db_cyc: in_val <= s2 and cnt <= 0.
- else: cnt <= cnt + 1.
REQ-023 SHALL therefore update in_val at edge k+2+cfg_db_cyc when pad_c is stable from just before edge k; cfg_db_cyc = 0 gives k+2.
REQ-024 SHALL restart the count from 0 when the input bounces back to in_val before the threshold; in_val does not change in that case.
REQ-025 SHALL use the >= comparison so that lowering cfg_db_cyc mid-count completes the filter on the next cycle; cnt never wraps.
REQ-026 SHALL set pend[n] on the same edge that in_val[n] changes, if:
- the change is 0->1 and cfg_rise_en[n] = 1, or
- the change is 1->0 and cfg_fall_en[n] = 1.
REQ-027 SHALL clear pend[n] on the edge where irq_clr[n] = 1; when a set and a clear occur on the same edge, the set wins.
REQ-028 SHALL hold pend[n] until it is cleared; changing cfg_*_en does not clear pending flags.
REQ-029 SHALL drive irq combinationally as |pend, with no extra latency.

Reset
REQ-030 SHALL, while rst = 1 at a clock edge, apply these reset values:
- pad_i = 0, pad_oen = all-1 (outputs off), pad_ren = all-0 (pull-ups on);
- s1 = s2 = 0, in_val = 0, cnt = 0, pend = 0, irq = 0.
REQ-031 SHALL let reset asserted mid-debounce or mid-edge abandon that operation; no pend is set from it.
REQ-032 SHALL take the first pad_c sample into s1 on the first edge after rst deasserts.

Configuration
REQ-033 SHALL use macro PAD_IO_DEBOUNCE_EN to compile the debounce filter in or out.
- Defined: REQ-021 to REQ-025 apply.
- Not defined: no counters exist, cfg_db_cyc is ignored, in_val <= s2 every cycle (latency k+2), and pend follows REQ-026 on in_val changes.

Verification
REQ-034 SHALL cover reset: assert rst for 2 cycles -> pad_oen = all-1, pad_ren = 0, pend = 0, irq = 0, in_val = 0.
REQ-035 SHALL cover output path: cfg_oe[3] = 1, cfg_out[3] = 1 at edge k -> pad_oen[3] = 0 and pad_i[3] = 1 after edge k+1; all other channels unchanged.
REQ-036 SHALL cover debounce: cfg_db_cyc = 4, pad_c[0] 0->1 held -> in_val[0] = 1 at edge k+6; with cfg_rise_en[0] = 1, pend[0] = 1 and irq = 1 on the same edge.
REQ-037 SHALL cover bounce: cfg_db_cyc = 4, pad_c[5] high for 3 cycles then low -> in_val[5] stays 0 and pend[5] stays 0.
REQ-038 SHALL cover the set/clear collision: pend[2] = 1, irq_clr[2] = 1 on the same edge as a new enabled falling edge on channel 2 -> pend[2] remains 1; irq_clr[2] alone on the next edge -> pend[2] = 0 and irq = 0.
REQ-039 SHALL cover the no-debounce build (PAD_IO_DEBOUNCE_EN undefined): pad_c[31] 0->1 -> in_val[31] = 1 at edge k+2 regardless of cfg_db_cyc = 255.
